// File: rtl/p405s_timer_spr_arb.sv
// rtl/p405s_timer_spr_arb.sv - core/debug arbiter and sequencer for timer SPR accesses
// Optional core stall while debug freezes: define P405S_TIMER_SPR_ARB_FREEZE_EN.
module p405s_timer_spr_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CB,
    input  logic        resetCore,
    input  logic        coreReq,
    input  logic        coreWr,
    input  logic [0:5]  coreSel,
    input  logic [0:31] coreData,
    output logic        coreAck,
    output logic [0:31] coreRdData,
    input  logic        dbgReq,
    input  logic        dbgWr,
    input  logic [2:0]  dbgSel,
    input  logic [0:31] dbgData,
    input  logic        dbgFreeze,
    output logic        dbgAck,
    output logic        dbgErr,
    output logic [0:31] dbgRdData,
    input  logic [0:31] TIM_sprDataBus,
    output logic [0:5]  ARB_timSprDcds,
    output logic [0:31] ARB_sprDataBus,
    output logic        ARB_mtSPR,
    output logic        ARB_sprHold
);

    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state;
    logic [2:0]  starveCnt;
    logic        capDbg;
    logic        capWr;
    logic        capErr;

    logic        coreOk;
    logic        grantCore;
    logic        grantDbg;
    logic [0:5]  dbgDec;
    logic        dbgIllegal;
    logic [0:5]  selNext;
    logic        wrNext;
    logic [0:31] dataNext;
    logic [0:31] rdValue;

`ifdef P405S_TIMER_SPR_ARB_FREEZE_EN
    assign coreOk = coreReq & ~dbgFreeze;
`else
    logic unusedFreeze;
    assign unusedFreeze = dbgFreeze;
    assign coreOk       = coreReq;
`endif

    // Core has fixed priority until debug has watched LIMIT core grants go by.
    assign grantCore = coreOk && !(dbgReq && (starveCnt == LIMIT));
    assign grantDbg  = dbgReq && !grantCore;

    always_comb begin
        dbgDec     = 6'b000000;
        dbgIllegal = 1'b0;
        case (dbgSel)
            3'd0:    dbgDec = 6'b100000;
            3'd1:    dbgDec = 6'b010000;
            3'd2:    dbgDec = 6'b001000;
            3'd3:    dbgDec = 6'b000100;
            3'd4:    dbgDec = 6'b000010;
            3'd5:    dbgDec = 6'b000001;
            default: dbgIllegal = 1'b1;
        endcase
    end

    assign selNext  = grantCore ? coreSel  : dbgDec;
    assign wrNext   = grantCore ? coreWr   : dbgWr;
    assign dataNext = grantCore ? coreData : dbgData;

    // With no decode active the timer mux carries nothing meaningful, so reads return zero.
    assign rdValue = (capWr || (ARB_timSprDcds == 6'b000000)) ? 32'h0 : TIM_sprDataBus;

    always_ff @(posedge CB) begin
        if (resetCore) begin
            state          <= IDLE;
            starveCnt      <= 3'd0;
            capDbg         <= 1'b0;
            capWr          <= 1'b0;
            capErr         <= 1'b0;
            coreAck        <= 1'b0;
            coreRdData     <= 32'h0;
            dbgAck         <= 1'b0;
            dbgErr         <= 1'b0;
            dbgRdData      <= 32'h0;
            ARB_timSprDcds <= 6'b000000;
            ARB_sprDataBus <= 32'h0;
            ARB_mtSPR      <= 1'b0;
            ARB_sprHold    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grantCore || grantDbg) begin
                        capDbg         <= grantDbg;
                        capWr          <= wrNext;
                        capErr         <= grantDbg && dbgIllegal;
                        ARB_timSprDcds <= selNext;
                        ARB_sprDataBus <= dataNext;
                        ARB_mtSPR      <= wrNext;
                        ARB_sprHold    <= !(wrNext && (selNext != 6'b000000));
                        state          <= ACC;
                        if (grantCore && dbgReq)
                            starveCnt <= (starveCnt == LIMIT) ? starveCnt : starveCnt + 3'd1;
                        else
                            starveCnt <= 3'd0;
                    end
                end
                ACC: begin
                    coreAck        <= !capDbg;
                    dbgAck         <= capDbg;
                    dbgErr         <= capDbg && capErr;
                    coreRdData     <= capDbg ? 32'h0 : rdValue;
                    dbgRdData      <= capDbg ? rdValue : 32'h0;
                    ARB_timSprDcds <= 6'b000000;
                    ARB_sprDataBus <= 32'h0;
                    ARB_mtSPR      <= 1'b0;
                    ARB_sprHold    <= 1'b1;
                    state          <= RSP;
                end
                RSP: begin
                    coreAck    <= 1'b0;
                    dbgAck     <= 1'b0;
                    dbgErr     <= 1'b0;
                    coreRdData <= 32'h0;
                    dbgRdData  <= 32'h0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_timer_spr_arb.sv
// tb/tb_p405s_timer_spr_arb.sv - scoreboard bench for p405s_timer_spr_arb
module tb_p405s_timer_spr_arb;

    logic        CB = 1'b0;
    logic        resetCore;
    logic        coreReq, coreWr, dbgReq, dbgWr, dbgFreeze;
    logic [0:5]  coreSel;
    logic [0:31] coreData, dbgData, TIM_sprDataBus;
    logic [2:0]  dbgSel;
    logic        coreAck, dbgAck, dbgErr, ARB_mtSPR, ARB_sprHold;
    logic [0:31] coreRdData, dbgRdData, ARB_sprDataBus;
    logic [0:5]  ARB_timSprDcds;

    int checks = 0;
    int errors = 0;
    int ackCount = 0;
    logic [33:0] expQ[$];   // {isDbg, err, data}

    p405s_timer_spr_arb #(.STARVE_LIMIT(4)) dut (
        .CB(CB), .resetCore(resetCore),
        .coreReq(coreReq), .coreWr(coreWr), .coreSel(coreSel), .coreData(coreData),
        .coreAck(coreAck), .coreRdData(coreRdData),
        .dbgReq(dbgReq), .dbgWr(dbgWr), .dbgSel(dbgSel), .dbgData(dbgData),
        .dbgFreeze(dbgFreeze), .dbgAck(dbgAck), .dbgErr(dbgErr), .dbgRdData(dbgRdData),
        .TIM_sprDataBus(TIM_sprDataBus), .ARB_timSprDcds(ARB_timSprDcds),
        .ARB_sprDataBus(ARB_sprDataBus), .ARB_mtSPR(ARB_mtSPR), .ARB_sprHold(ARB_sprHold)
    );

    always #5 CB = ~CB;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CB);
        #1;
    endtask

    always @(negedge CB) begin
        if (coreReq)
            assert ($countones(coreSel) <= 1) else $error("multi-hot coreSel driven");
    end

    // Monitor: every ack is matched against the oldest expected response.
    always @(negedge CB) begin
        logic [33:0] e;
        if (coreAck && dbgAck) begin
            checks++;
            errors++;
            $display("FAIL both_acks: got coreAck=1 dbgAck=1 expected one");
        end else if (coreAck || dbgAck) begin
            ackCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got dbgAck=%0b with empty queue expected none", dbgAck);
            end else begin
                e = expQ.pop_front();
                chk("ack_who", {31'h0, dbgAck}, {31'h0, e[33]});
                chk("ack_data", dbgAck ? dbgRdData : coreRdData, e[31:0]);
                chk("ack_err", {31'h0, dbgErr}, {31'h0, e[32]});
            end
        end
    end

    task automatic waitAcks(input int target, input bit dropEach, input int maxCycles);
        for (int i = 0; i < maxCycles && ackCount < target; i++) begin
            @(negedge CB);
            #1;
            if (dropEach && coreAck) coreReq = 1'b0;
            if (dropEach && dbgAck)  dbgReq  = 1'b0;
        end
        checks++;
        if (ackCount < target) begin
            errors++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", ackCount, target);
        end
    endtask

    // One complete access from an idle arbiter; ACC outputs checked inline, ack via scoreboard.
    task automatic access(input bit isDbg, input logic wr, input logic [0:5] cSel,
                          input logic [2:0] dSel, input logic [0:31] data, input logic [0:31] tim,
                          input logic [0:5] expDcd, input logic expHold,
                          input logic [0:31] expRd, input logic expErr, input string nm);
        if (isDbg) begin
            dbgWr = wr; dbgSel = dSel; dbgData = data; dbgReq = 1'b1;
        end else begin
            coreWr = wr; coreSel = cSel; coreData = data; coreReq = 1'b1;
        end
        expQ.push_back({isDbg, expErr, expRd});
        tick;
        chk({nm, "_dcd"}, {26'h0, ARB_timSprDcds}, {26'h0, expDcd});
        chk({nm, "_mtspr"}, {31'h0, ARB_mtSPR}, {31'h0, wr});
        chk({nm, "_hold"}, {31'h0, ARB_sprHold}, {31'h0, expHold});
        chk({nm, "_wdata"}, ARB_sprDataBus, data);
        TIM_sprDataBus = tim;
        tick;
        coreReq = 1'b0;
        dbgReq  = 1'b0;
        tick;
        chk({nm, "_idle_hold"}, {31'h0, ARB_sprHold}, 32'h1);
    endtask

    initial begin
        int base;
        resetCore = 1'b1;
        coreReq = 0; coreWr = 0; coreSel = '0; coreData = '0;
        dbgReq = 0; dbgWr = 0; dbgSel = '0; dbgData = '0; dbgFreeze = 0;
        TIM_sprDataBus = '0;
        tick;
        tick;
        chk("rst_hold", {31'h0, ARB_sprHold}, 32'h1);
        chk("rst_mtspr", {31'h0, ARB_mtSPR}, 32'h0);
        chk("rst_dcd", {26'h0, ARB_timSprDcds}, 32'h0);
        chk("rst_acks", {30'h0, coreAck, dbgAck}, 32'h0);
        resetCore = 1'b0;
        tick;

        access(0, 1, 6'b001000, 3'd0, 32'h0000_1234, 32'hFFFF_FFFF, 6'b001000, 0, 32'h0, 0, "core_wr");
        access(1, 0, 6'b000000, 3'd4, 32'h0, 32'hDEAD_BEEF, 6'b000010, 1, 32'hDEAD_BEEF, 0, "dbg_rd");
        access(1, 1, 6'b000000, 3'd7, 32'h0000_0055, 32'h1111_2222, 6'b000000, 1, 32'h0, 1, "dbg_ill");
        access(0, 0, 6'b000000, 3'd0, 32'h0, 32'h1234_5678, 6'b000000, 1, 32'h0, 0, "core_nosel");
        access(0, 0, 6'b100000, 3'd0, 32'h0, 32'hCAFE_0001, 6'b100000, 1, 32'hCAFE_0001, 0, "core_rd");

        // Starvation: both requesters held high for ten accesses.
        TIM_sprDataBus = 32'hA5A5_0F0F;
        coreWr = 0; coreSel = 6'b000010; dbgWr = 0; dbgSel = 3'd5;
        for (int k = 0; k < 10; k++)
            expQ.push_back({(k == 4 || k == 9) ? 1'b1 : 1'b0, 1'b0, 32'hA5A5_0F0F});
        base = ackCount;
        coreReq = 1; dbgReq = 1;
        waitAcks(base + 10, 0, 60);
        coreReq = 0; dbgReq = 0;
        tick;
        tick;

        // Reset during ACC drops the access; the still-held request then completes.
        coreWr = 1; coreSel = 6'b100000; coreData = 32'h0000_00AA; coreReq = 1;
        tick;
        chk("rstacc_mtspr", {31'h0, ARB_mtSPR}, 32'h1);
        resetCore = 1'b1;
        tick;
        chk("rstacc_hold", {31'h0, ARB_sprHold}, 32'h1);
        chk("rstacc_dcd", {26'h0, ARB_timSprDcds}, 32'h0);
        chk("rstacc_noack", {31'h0, coreAck}, 32'h0);
        resetCore = 1'b0;
        expQ.push_back({1'b0, 1'b0, 32'h0});
        base = ackCount;
        waitAcks(base + 1, 1, 10);
        tick;
        tick;

        // Freeze with both requesters pending.
        TIM_sprDataBus = 32'h0BAD_F00D;
        coreWr = 0; coreSel = 6'b100000; dbgWr = 0; dbgSel = 3'd3;
        base = ackCount;
`ifdef P405S_TIMER_SPR_ARB_FREEZE_EN
        expQ.push_back({1'b1, 1'b0, 32'h0BAD_F00D});
        expQ.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
        dbgFreeze = 1; coreReq = 1; dbgReq = 1;
        waitAcks(base + 1, 1, 10);
        repeat (4) tick;
        chk("frz_stall_dcd", {26'h0, ARB_timSprDcds}, 32'h0);
        chk("frz_stall_acks", ackCount, base + 1);
        dbgFreeze = 0;
        waitAcks(base + 2, 1, 10);
`else
        expQ.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
        expQ.push_back({1'b1, 1'b0, 32'h0BAD_F00D});
        dbgFreeze = 1; coreReq = 1; dbgReq = 1;
        waitAcks(base + 2, 1, 20);
        dbgFreeze = 0;
`endif
        repeat (4) tick;
        chk("queue_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/p405s_timer_spr_arb.md
Name: p405s_timer_spr_arb

Overview:
- Arbitrates and sequences timer SPR accesses (TCR, TSR-reset, TSR-set, PIT, TBL, TBH) between the core execute pipe and the debug/JTAG port.
- Sits in front of the timer top level. It drives that block's one-hot SPR decodes, SPR write data, mtSPR and sprHold.
- Returns timer read data to the requester that won arbitration.
- Uses fixed core priority with a debug anti-starvation limit.

Parameters:
- STARVE_LIMIT, 4: number of consecutive core grants while debug waits before debug is forced to win; legal range 1..7.

Ports:
- CB  in  1  clock; all state changes on rising edge
- resetCore  in  1  synchronous, active-high reset
- coreReq  in  1  core access request; held until coreAck
- coreWr  in  1  1=mtspr, 0=mfspr
- coreSel  in  6  one-hot timer SPR select [0:5] = TCR, TSR-rst, TSR-set, PIT, TBL, TBH
- coreData  in  32  core write data [0:31]
- coreAck  out  1  one-cycle access-complete pulse
- coreRdData  out  32  read data, valid with coreAck
- dbgReq  in  1  debug access request; held until dbgAck
- dbgWr  in  1  1=write, 0=read
- dbgSel  in  3  encoded SPR index 0..5; 6 and 7 are illegal
- dbgData  in  32  debug write data
- dbgFreeze  in  1  debug freeze request (see Optional Feature)
- dbgAck  out  1  one-cycle access-complete pulse
- dbgErr  out  1  illegal select; valid with dbgAck
- dbgRdData  out  32  read data, valid with dbgAck
- TIM_sprDataBus  in  32  timer read mux output
- ARB_timSprDcds  out  6  one-hot decodes to timer
- ARB_sprDataBus  out  32  write data to timer
- ARB_mtSPR  out  1  write strobe to timer
- ARB_sprHold  out  1  hold to timer; 1 blocks timer SPR writes

Behaviour:
- Clock and reset: one clock, CB. resetCore is synchronous and active-high.
- FSM states: IDLE, ACC, RSP. All outputs are decoded from registered state and registered request capture.
- Reset values:
  - state=IDLE, starveCnt=0.
  - ARB_sprHold=1.
  - All other outputs 0.
- IDLE:
  - Samples requests.
  - Grants core if coreReq, unless dbgReq and starveCnt==STARVE_LIMIT, in which case debug is granted.
  - Otherwise grants debug if dbgReq.
  - On grant, captures winner id, wr, sel (debug sel decoded to one-hot; illegal index gives all zeros plus an error flag) and data. Next state is ACC.
  - No request: stays in IDLE.
- ACC (exactly one cycle):
  - ARB_timSprDcds = captured one-hot; ARB_sprDataBus = captured data.
  - ARB_mtSPR = wr.
  - ARB_sprHold = 0 for a legal write, 1 otherwise.
  - TIM_sprDataBus is captured at the end of ACC into the read register (forced to 0 if the error flag is set). Next state is RSP.
- RSP (one cycle):
  - Winner's ack = 1. Read data = captured value for reads, 0 for writes.
  - dbgErr = error flag (debug winner only).
  - Decodes, mtSPR and data return to 0; sprHold = 1. Next state is IDLE.
- Latency: request seen in IDLE at cycle N → ack at N+2. Minimum 3 cycles per access.
- Requesters deassert req the cycle after ack. A req still high when IDLE is re-entered starts a new access.
- starveCnt:
  - Increments on a core grant while dbgReq=1, saturating at STARVE_LIMIT.
  - Clears on any debug grant, or on a core grant with dbgReq=0.
- Simultaneous core and debug requests with starveCnt<STARVE_LIMIT: core wins and debug keeps waiting.
- coreSel with zero bits set: access runs with no decode, ack returns rdData=0. coreSel with more than one bit set is illegal; the bench asserts against it.
- Request changes during ACC or RSP are ignored; captured values are used.
- resetCore mid-operation:
  - Next edge forces IDLE, starveCnt=0, all outputs to reset values.
  - A pending ack is dropped; the requester must re-issue.

Optional Feature:
- Macro: P405S_TIMER_SPR_ARB_FREEZE_EN.
- Defined: while dbgFreeze=1, coreReq is not granted in IDLE (core stalls); debug accesses proceed normally. An access already in ACC/RSP completes.
- Undefined: dbgFreeze is ignored; the port remains for a stable interface.

Test Plan:
- Core write: coreReq=1, coreWr=1, coreSel=6'b001000, coreData=32'h0000_1234 → one ACC cycle with ARB_timSprDcds=001000, ARB_mtSPR=1, ARB_sprHold=0, data 0x1234; coreAck at N+2.
- Debug read: dbgReq=1, dbgWr=0, dbgSel=4, TIM_sprDataBus=32'hDEAD_BEEF in ACC → dbgAck at N+2, dbgRdData=0xDEADBEEF, dbgErr=0, ARB_mtSPR=0 throughout.
- Illegal debug select: dbgSel=7, write → ACC with decodes=0 and sprHold=1; dbgAck=1, dbgErr=1, dbgRdData=0.
- Starvation: coreReq and dbgReq held high continuously, STARVE_LIMIT=4 → grant order core ×4, debug, core ×4, debug. Each debug grant clears starveCnt.
- Reset mid-access: resetCore=1 during ACC of a core write → next cycle IDLE, ARB_sprHold=1, no coreAck. coreReq still high afterwards → a fresh access completes normally.
- Freeze (macro defined): dbgFreeze=1 with coreReq and dbgReq both high → only debug is acked; coreAck follows 3 cycles after dbgFreeze drops. With the macro undefined, core is acked first.
